// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for bin2bcd_seq: start/bin request in, busy/done/bcd/error result out.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  error;

    modport master (
        output start, bin,
        input  busy, done, bcd, error
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, error
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional overflow detection is enabled by defining BIN2BCD_OVF_EN.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    bin2bcd_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic [BW-1:0]    digits_r, digits_s;
    logic [BW-1:0]    bcd_r, bcd_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             error_r, error_s;
    logic [DIGITS-1:0] cin_s;
    logic [BW-1:0]    step_s;
`ifdef BIN2BCD_OVF_EN
    logic             ovf_r, ovf_s;
`endif

    // Add-3 correction on the low three bits, then shift in the carry from below.
    // The corrected digit's bit 3 is exactly (d >= 5), which becomes the carry upward.
    function automatic logic [3:0] dd_step(input logic [3:0] d, input logic cin);
        logic [2:0] low;
        if (d >= 4'd5) begin
            low = d[2:0] + 3'd3;
        end else begin
            low = d[2:0];
        end
        return {low, cin};
    endfunction

    // One double-dabble iteration of the working digits
    always_comb begin
        cin_s    = '0;
        step_s   = '0;
        cin_s[0] = shift_r[WIDTH-1];
        for (int i = 1; i < DIGITS; i++) begin
            cin_s[i] = (digits_r[4*(i-1) +: 4] >= 4'd5);
        end
        for (int i = 0; i < DIGITS; i++) begin
            step_s[4*i +: 4] = dd_step(digits_r[4*i +: 4], cin_s[i]);
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_s  = state_r;
        shift_s  = shift_r;
        digits_s = digits_r;
        cnt_s    = cnt_r;
        bcd_s    = bcd_r;
        error_s  = error_r;
        busy_s   = (state_r == SHIFT);
        done_s   = (state_r == DONE);
`ifdef BIN2BCD_OVF_EN
        ovf_s    = ovf_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    shift_s  = bus.bin;
                    digits_s = '0;
                    cnt_s    = CW'(WIDTH);
`ifdef BIN2BCD_OVF_EN
                    ovf_s    = 1'b0;
`endif
                    state_s  = SHIFT;
                end else begin
                    state_s  = IDLE;
                end
            end
            SHIFT: begin
                digits_s = step_s;
                shift_s  = {shift_r[WIDTH-2:0], 1'b0};
                cnt_s    = cnt_r - CW'(1);
`ifdef BIN2BCD_OVF_EN
                ovf_s    = ovf_r | (digits_r[BW-4 +: 4] >= 4'd5);
`endif
                if (cnt_r == CW'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                bcd_s   = digits_r;
`ifdef BIN2BCD_OVF_EN
                error_s = ovf_r;
`else
                error_s = 1'b0;
`endif
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any conversion in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            shift_r  <= '0;
            digits_r <= '0;
            cnt_r    <= '0;
            bcd_r    <= '0;
            error_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef BIN2BCD_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            shift_r  <= shift_s;
            digits_r <= digits_s;
            cnt_r    <= cnt_s;
            bcd_r    <= bcd_s;
            error_r  <= error_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
`ifdef BIN2BCD_OVF_EN
            ovf_r    <= ovf_s;
`endif
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.bcd   = bcd_r;
    assign bus.error = error_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (WIDTH=8 with DIGITS=3 and DIGITS=2 instances).
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq_if #(.WIDTH(8), .DIGITS(3)) ifa ();
    bin2bcd_seq_if #(.WIDTH(8), .DIGITS(2)) ifb ();

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic digits_ok(input logic [11:0] b);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
    endfunction

    // Start one conversion on DUT a (sel=0) or b (sel=1) and wait for done.
    task automatic conv(input bit sel, input logic [7:0] v, output logic [11:0] r,
                        output logic e, output int lat, output int bcnt);
        r = 12'h000; e = 1'b0; lat = 0; bcnt = 0;
        if (sel) begin ifb.start = 1'b1; ifb.bin = v; end
        else     begin ifa.start = 1'b1; ifa.bin = v; end
        tick();
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (sel) begin
                if (ifb.busy) bcnt++;
                if (ifb.done) begin lat = c; r = {4'd0, ifb.bcd}; e = ifb.error; break; end
            end else begin
                if (ifa.busy) bcnt++;
                if (ifa.done) begin lat = c; r = ifa.bcd; e = ifa.error; break; end
            end
        end
    endtask

    initial begin
        logic [11:0] r;
        logic        e;
        int          lat, bcnt, t1, t2, ndone, nbusy;
        logic [11:0] exp_bcd;

        ifa.start = 1'b0; ifa.bin = 8'd0;
        ifb.start = 1'b0; ifb.bin = 8'd0;
        reset_n = 1'b0;
        tick(); tick();
        chk("rst_busy",  {31'd0, ifa.busy},  32'd0);
        chk("rst_done",  {31'd0, ifa.done},  32'd0);
        chk("rst_bcd",   {20'd0, ifa.bcd},   32'd0);
        chk("rst_error", {31'd0, ifa.error}, 32'd0);
        chk("rst_bcd_b", {24'd0, ifb.bcd},   32'd0);
        reset_n = 1'b1;
        tick();

        // bin=0: latency, busy length, result
        conv(1'b0, 8'd0, r, e, lat, bcnt);
        chk("zero_lat",  lat, 32'd9);
        chk("zero_busy", bcnt, 32'd8);
        chk("zero_bcd",  {20'd0, r}, 32'h000);
        chk("zero_err",  {31'd0, e}, 32'd0);
        chk("zero_busy_at_done", {31'd0, ifa.busy}, 32'd0);

        // back-to-back 9, 10, 255
        conv(1'b0, 8'd9, r, e, lat, bcnt);
        t1 = cyc;
        chk("b2b9_bcd", {20'd0, r}, 32'h009);
        chk("b2b9_dig", {31'd0, digits_ok(r)}, 32'd1);
        conv(1'b0, 8'd10, r, e, lat, bcnt);
        t2 = cyc;
        chk("b2b10_bcd", {20'd0, r}, 32'h010);
        chk("b2b10_dig", {31'd0, digits_ok(r)}, 32'd1);
        chk("b2b_space1", t2 - t1, 32'd10);
        t1 = t2;
        conv(1'b0, 8'd255, r, e, lat, bcnt);
        t2 = cyc;
        chk("b2b255_bcd", {20'd0, r}, 32'h255);
        chk("b2b255_dig", {31'd0, digits_ok(r)}, 32'd1);
        chk("b2b_space2", t2 - t1, 32'd10);
        chk("b2b255_busy", bcnt, 32'd8);

        // start held during conversion, bin changed mid-way
        tick();
        ndone = 0;
        r = 12'hfff;
        ifa.start = 1'b1; ifa.bin = 8'd128;
        tick();
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 4) ifa.bin = 8'd7;
            if (ifa.done) begin ndone++; r = ifa.bcd; end
            ifa.start = (c < 9);
        end
        ifa.start = 1'b0;
        chk("hold_ndone", ndone, 32'd1);
        chk("hold_bcd", {20'd0, r}, 32'h128);

        // reset at E4 of a conversion of 200
        ndone = 0;
        ifa.start = 1'b1; ifa.bin = 8'd200;
        tick();
        ifa.start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 3) reset_n = 1'b0;
            if (c == 4) reset_n = 1'b1;
            if (ifa.done) ndone++;
        end
        chk("rstmid_ndone", ndone, 32'd0);
        chk("rstmid_busy",  {31'd0, ifa.busy},  32'd0);
        chk("rstmid_bcd",   {20'd0, ifa.bcd},   32'd0);
        chk("rstmid_error", {31'd0, ifa.error}, 32'd0);
        conv(1'b0, 8'd200, r, e, lat, bcnt);
        chk("rstmid_redo_bcd", {20'd0, r}, 32'h200);
        chk("rstmid_redo_lat", lat, 32'd9);

        // reset and start on the same edge: reset wins
        tick();
        reset_n = 1'b0; ifa.start = 1'b1; ifa.bin = 8'd50;
        tick();
        reset_n = 1'b1; ifa.start = 1'b0;
        ndone = 0; nbusy = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ifa.done) ndone++;
            if (ifa.busy) nbusy++;
        end
        chk("rststart_done", ndone, 32'd0);
        chk("rststart_busy", nbusy, 32'd0);

        // DIGITS=2 instance: truncation and overflow flag
        conv(1'b1, 8'd99, r, e, lat, bcnt);
        chk("d2_99_bcd", {20'd0, r}, 32'h099);
        chk("d2_99_err", {31'd0, e}, 32'd0);
        conv(1'b1, 8'd100, r, e, lat, bcnt);
        chk("d2_100_bcd", {20'd0, r}, 32'h000);
`ifdef BIN2BCD_OVF_EN
        chk("d2_100_err", {31'd0, e}, 32'd1);
`else
        chk("d2_100_err", {31'd0, e}, 32'd0);
`endif
        conv(1'b1, 8'd255, r, e, lat, bcnt);
        chk("d2_255_bcd", {20'd0, r}, 32'h055);
`ifdef BIN2BCD_OVF_EN
        chk("d2_255_err", {31'd0, e}, 32'd1);
`else
        chk("d2_255_err", {31'd0, e}, 32'd0);
`endif
        chk("d2_255_lat", lat, 32'd9);

        // exhaustive sweep on DIGITS=3: decode and digit-range filter
        for (int v = 0; v < 256; v++) begin
            conv(1'b0, 8'(v), r, e, lat, bcnt);
            exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            chk($sformatf("sweep_bcd_%0d", v), {20'd0, r}, {20'd0, exp_bcd});
            chk($sformatf("sweep_dec_%0d", v),
                32'(r[11:8]) * 32'd100 + 32'(r[7:4]) * 32'd10 + 32'(r[3:0]), 32'(v));
            chk($sformatf("sweep_filter_%0d", v), {31'd0, digits_ok(r)}, 32'd1);
            chk($sformatf("sweep_err_%0d", v), {31'd0, e}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
